// File: rtl/sd_spi_responder_if.sv
// SPI pin bundle of the SD responder plus its command-status outputs.
// The master modport is the host/bench side; slave is the card side.
interface sd_spi_responder_if;
  logic       spi_clk;
  logic       spi_di;
  logic       spi_cs;
  logic       spi_do;
  logic       cmd_valid;
  logic [5:0] cmd_index;
  logic       card_ready;

  modport master (
    output spi_clk, spi_di, spi_cs,
    input  spi_do, cmd_valid, cmd_index, card_ready
  );

  modport slave (
    input  spi_clk, spi_di, spi_cs,
    output spi_do, cmd_valid, cmd_index, card_ready
  );
endinterface

// File: rtl/sd_spi_responder.sv
// SPI-mode SD card responder: oversampled SCLK/CS/MOSI, 48-bit command decode, R1/R3/R7 replies on MISO.
// Define SD_RESP_CRC_EN to check the CRC7 of incoming commands (CRC field ignored otherwise).
//
// state       | meaning
// RX_HUNT     | waiting for a start bit (MOSI low on rising SCLK); blocked while TX busy
// RX_FRAME    | shifting in the remaining 47 command bits
// TX_IDLE     | MISO held high
// TX_FILL     | NCR filler bits (all ones) on falling SCLK
// TX_RESP     | response bytes shifted out MSB first on falling SCLK
// CARD_UNINIT | only CMD0 is answered
// CARD_IDLE   | initialising; R1 idle bit set
// CARD_READY  | ACMD41 sequence complete
module sd_spi_responder #(
  parameter int unsigned NCR_BYTES  = 1,
  parameter int unsigned BUSY_COUNT = 3,
  parameter logic [31:0] OCR_VALUE  = 32'hC0FF_8000
) (
  input  logic              clk,
  input  logic              rst_n,
  sd_spi_responder_if.slave bus
);

  localparam logic [6:0] FILL_BITS = 7'(NCR_BYTES * 8);
  localparam logic [7:0] BUSY_LIM  = 8'(BUSY_COUNT);

  typedef enum logic       {RX_HUNT, RX_FRAME} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_FILL, TX_RESP} tx_state_t;
  typedef enum logic [1:0] {CARD_UNINIT, CARD_IDLE, CARD_READY} card_state_t;

  logic [1:0] sclk_sync_q, cs_sync_q, di_sync_q;
  logic       sclk_dly_q;
  logic       sclk_s, cs_s, di_s, sclk_rise, sclk_fall;

  assign sclk_s    = sclk_sync_q[1];
  assign cs_s      = cs_sync_q[1];
  assign di_s      = di_sync_q[1];
  assign sclk_rise = sclk_s & ~sclk_dly_q;
  assign sclk_fall = ~sclk_s & sclk_dly_q;

  rx_state_t   rx_state_q, rx_state_d;
  logic [5:0]  rx_cnt_q, rx_cnt_d;
  logic [45:0] rx_sr_q, rx_sr_d;
  tx_state_t   tx_state_q, tx_state_d;
  logic [6:0]  tx_cnt_q, tx_cnt_d;
  logic [39:0] tx_sr_q, tx_sr_d;
  logic        tx_long_q, tx_long_d;
  logic        spi_do_q, spi_do_d;
  logic        cmd_valid_q, cmd_valid_d;
  logic [5:0]  cmd_index_q, cmd_index_d;
  logic        card_ready_q, card_ready_d;
  card_state_t card_q, card_d;
  logic [7:0]  busy_q, busy_d;
  logic        app_q, app_d;

  // Full frame on the final rising edge: bits 46..1 from the shifter, bit 0 live.
  logic [46:0] frame;
  logic [5:0]  f_idx;
  logic [31:0] f_arg;
  logic        crc_bad;

  assign frame = {rx_sr_q, di_s};
  assign f_idx = frame[45:40];
  assign f_arg = frame[39:8];

  logic        idle_bit, respond, long_resp;
  logic [7:0]  r1;
  logic [31:0] resp_word;

`ifdef SD_RESP_CRC_EN
  logic [6:0] crc_q, crc_d;
  logic       unused_arg_hi;

  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic b);
    logic fb;
    fb = b ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  assign crc_bad       = (crc_q != frame[7:1]);
  assign unused_arg_hi = ^f_arg[31:12];

  // The start bit is zero and leaves the CRC at zero, so HUNT simply holds it cleared.
  always_comb begin
    crc_d = crc_q;
    if (cs_s || rx_state_q == RX_HUNT) begin
      crc_d = '0;
    end else if (sclk_rise && rx_cnt_q <= 6'd39) begin
      crc_d = crc7_step(crc_q, di_s);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) crc_q <= '0;
    else        crc_q <= crc_d;
  end
`else
  logic unused_bits;

  assign crc_bad     = 1'b0;
  assign unused_bits = ^{f_arg[31:12], frame[7:1]};
`endif

  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q;
    rx_sr_d     = rx_sr_q;
    tx_state_d  = tx_state_q;
    tx_cnt_d    = tx_cnt_q;
    tx_sr_d     = tx_sr_q;
    tx_long_d   = tx_long_q;
    spi_do_d    = spi_do_q;
    cmd_valid_d = 1'b0;
    cmd_index_d = cmd_index_q;
    card_d      = card_q;
    busy_d      = busy_q;
    app_d       = app_q;
    idle_bit    = (card_q != CARD_READY);
    r1          = {7'd0, idle_bit};
    resp_word   = 32'hFFFF_FFFF;
    respond     = 1'b0;
    long_resp   = 1'b0;

    if (cs_s) begin
      rx_state_d = RX_HUNT;
      rx_cnt_d   = '0;
      tx_state_d = TX_IDLE;
      tx_cnt_d   = '0;
      spi_do_d   = 1'b1;
    end else begin
      case (rx_state_q)
        RX_HUNT: begin
          if (sclk_rise && !di_s && tx_state_q == TX_IDLE) begin
            rx_state_d = RX_FRAME;
            rx_cnt_d   = 6'd1;
          end
        end
        RX_FRAME: begin
          if (sclk_rise) begin
            if (rx_cnt_q == 6'd47) begin
              rx_state_d = RX_HUNT;
              rx_cnt_d   = '0;
              if (frame[46] && frame[0]) begin
                cmd_valid_d = 1'b1;
                cmd_index_d = f_idx;
                app_d       = 1'b0;
                respond     = 1'b1;
                if (crc_bad) begin
                  r1 = 8'h08 | {7'd0, idle_bit};
                end else if (f_idx == 6'd0) begin
                  card_d = CARD_IDLE;
                  busy_d = '0;
                  r1     = 8'h01;
                end else if (card_q == CARD_UNINIT) begin
                  respond = 1'b0;
                end else begin
                  case (f_idx)
                    6'd8: begin
                      long_resp = 1'b1;
                      resp_word = {20'h0, f_arg[11:0]};
                    end
                    6'd55: app_d = 1'b1;
                    6'd41: begin
                      if (!app_q) begin
                        r1 = 8'h04 | {7'd0, idle_bit};
                      end else if (busy_q < BUSY_LIM) begin
                        r1     = 8'h01;
                        busy_d = busy_q + 8'd1;
                      end else begin
                        card_d = CARD_READY;
                        r1     = 8'h00;
                      end
                    end
                    6'd58: begin
                      long_resp = 1'b1;
                      resp_word = {card_q == CARD_READY, OCR_VALUE[30:0]};
                    end
                    default: r1 = 8'h04 | {7'd0, idle_bit};
                  endcase
                end
                if (respond) begin
                  tx_state_d = TX_FILL;
                  tx_cnt_d   = FILL_BITS;
                  tx_sr_d    = {r1, resp_word};
                  tx_long_d  = long_resp;
                end
              end
            end else begin
              rx_sr_d  = {rx_sr_q[44:0], di_s};
              rx_cnt_d = rx_cnt_q + 6'd1;
            end
          end
        end
        default: rx_state_d = RX_HUNT;
      endcase

      case (tx_state_q)
        TX_FILL: begin
          if (sclk_fall) begin
            if (tx_cnt_q != '0) begin
              spi_do_d = 1'b1;
              tx_cnt_d = tx_cnt_q - 7'd1;
            end else begin
              spi_do_d   = tx_sr_q[39];
              tx_sr_d    = {tx_sr_q[38:0], 1'b1};
              tx_state_d = TX_RESP;
              tx_cnt_d   = tx_long_q ? 7'd39 : 7'd7;
            end
          end
        end
        TX_RESP: begin
          if (sclk_fall) begin
            if (tx_cnt_q != '0) begin
              spi_do_d = tx_sr_q[39];
              tx_sr_d  = {tx_sr_q[38:0], 1'b1};
              tx_cnt_d = tx_cnt_q - 7'd1;
            end else begin
              spi_do_d   = 1'b1;
              tx_state_d = TX_IDLE;
            end
          end
        end
        default: ;
      endcase
    end

    card_ready_d = (card_d == CARD_READY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q  <= '0;
      cs_sync_q    <= 2'b11;
      di_sync_q    <= 2'b11;
      sclk_dly_q   <= 1'b0;
      rx_state_q   <= RX_HUNT;
      rx_cnt_q     <= '0;
      rx_sr_q      <= '0;
      tx_state_q   <= TX_IDLE;
      tx_cnt_q     <= '0;
      tx_sr_q      <= '1;
      tx_long_q    <= 1'b0;
      spi_do_q     <= 1'b1;
      cmd_valid_q  <= 1'b0;
      cmd_index_q  <= '0;
      card_ready_q <= 1'b0;
      card_q       <= CARD_UNINIT;
      busy_q       <= '0;
      app_q        <= 1'b0;
    end else begin
      sclk_sync_q  <= {sclk_sync_q[0], bus.spi_clk};
      cs_sync_q    <= {cs_sync_q[0], bus.spi_cs};
      di_sync_q    <= {di_sync_q[0], bus.spi_di};
      sclk_dly_q   <= sclk_s;
      rx_state_q   <= rx_state_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_sr_q      <= rx_sr_d;
      tx_state_q   <= tx_state_d;
      tx_cnt_q     <= tx_cnt_d;
      tx_sr_q      <= tx_sr_d;
      tx_long_q    <= tx_long_d;
      spi_do_q     <= spi_do_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_index_q  <= cmd_index_d;
      card_ready_q <= card_ready_d;
      card_q       <= card_d;
      busy_q       <= busy_d;
      app_q        <= app_d;
    end
  end

  assign bus.spi_do     = spi_do_q;
  assign bus.cmd_valid  = cmd_valid_q;
  assign bus.cmd_index  = cmd_index_q;
  assign bus.card_ready = card_ready_q;

endmodule

// File: tb/tb_sd_spi_responder.sv
// Bench for sd_spi_responder: SPI mode-0 host driving directed and random commands,
// replies compared against a card model built from the command rules.
module tb_sd_spi_responder;
  localparam int          HALF = 4;
  localparam int          NCR  = 1;
  localparam int          BUSY = 3;
  localparam logic [31:0] OCR  = 32'hC0FF_8000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sd_spi_responder_if bus();

  sd_spi_responder #(.NCR_BYTES(NCR), .BUSY_COUNT(BUSY), .OCR_VALUE(OCR)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int         checks = 0;
  int         errors = 0;
  int         nvalid = 0;
  logic [5:0] last_idx = '0;
  logic       last_rdy = 1'b0;

  // Card model: 0 uninit, 1 idle, 2 ready
  int         m_state = 0;
  int         m_busy = 0;
  bit         m_app = 1'b0;
  logic [7:0] exp_b [7];

  always @(negedge clk) begin
    if (rst_n && bus.cmd_valid === 1'b1) begin
      nvalid++;
      last_idx = bus.cmd_index;
      last_rdy = bus.card_ready;
    end
  end

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [6:0] c;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      if (d[i] ^ c[6]) c = {c[5:0], 1'b0} ^ 7'h09;
      else             c = {c[5:0], 1'b0};
    end
    return c;
  endfunction

  function automatic void model_cmd(input logic [5:0] idx, input logic [31:0] arg, input bit crc_ok);
    logic [7:0]  r[$];
    logic [7:0]  idle;
    logic [31:0] ocr;
    bit          app_prev;
    foreach (exp_b[i]) exp_b[i] = 8'hFF;
    idle     = (m_state == 2) ? 8'h00 : 8'h01;
    app_prev = m_app;
    m_app    = 1'b0;
    if (!crc_ok) begin
      r.push_back(idle | 8'h08);
    end else if (idx == 6'd0) begin
      m_state = 1;
      m_busy  = 0;
      r.push_back(8'h01);
    end else if (m_state != 0) begin
      case (idx)
        6'd8: begin
          r.push_back(idle);
          r.push_back(8'h00);
          r.push_back(8'h00);
          r.push_back({4'h0, arg[11:8]});
          r.push_back(arg[7:0]);
        end
        6'd55: begin
          r.push_back(idle);
          m_app = 1'b1;
        end
        6'd41: begin
          if (!app_prev) r.push_back(idle | 8'h04);
          else if (m_busy < BUSY) begin
            r.push_back(8'h01);
            m_busy++;
          end else begin
            m_state = 2;
            r.push_back(8'h00);
          end
        end
        6'd58: begin
          ocr     = OCR;
          ocr[31] = (m_state == 2);
          r.push_back(idle);
          r.push_back(ocr[31:24]);
          r.push_back(ocr[23:16]);
          r.push_back(ocr[15:8]);
          r.push_back(ocr[7:0]);
        end
        default: r.push_back(idle | 8'h04);
      endcase
    end
    foreach (r[i]) exp_b[NCR + i] = r[i];
  endfunction

  task automatic xfer_bit(input logic mo, output logic mi);
    bus.spi_di = mo;
    repeat (HALF) @(negedge clk);
    mi = bus.spi_do;
    bus.spi_clk = 1'b1;
    repeat (HALF) @(negedge clk);
    bus.spi_clk = 1'b0;
  endtask

  task automatic cs_pulse();
    bus.spi_cs = 1'b1;
    repeat (12) @(negedge clk);
    bus.spi_cs = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  // Sends one frame and reads nbytes of reply; fewer than 7 means CS is raised mid-reply.
  task automatic do_cmd(input logic [5:0] idx, input logic [31:0] arg, input bit bad_crc,
                        input int nbytes, input string tag);
    logic [6:0]  c;
    logic [47:0] f;
    logic        mi;
    logic [7:0]  got;
    int          nv0;
    bit          crc_ok;
    c      = bad_crc ? 7'h00 : crc7({2'b01, idx, arg});
    crc_ok = 1'b1;
`ifdef SD_RESP_CRC_EN
    crc_ok = !bad_crc;
`endif
    f   = {2'b01, idx, arg, c, 1'b1};
    nv0 = nvalid;
    model_cmd(idx, arg, crc_ok);
    for (int i = 47; i >= 0; i--) xfer_bit(f[i], mi);
    for (int b = 0; b < nbytes; b++) begin
      got = '0;
      for (int k = 0; k < 8; k++) begin
        xfer_bit(1'b1, mi);
        got = {got[6:0], mi};
      end
      check($sformatf("%s_byte%0d", tag, b), 40'(got), 40'(exp_b[b]));
    end
    check({tag, "_valid_count"}, 40'(nvalid), 40'(nv0 + 1));
    check({tag, "_cmd_index"}, 40'(last_idx), 40'(idx));
    check({tag, "_ready_at_valid"}, 40'(last_rdy), 40'(m_state == 2));
    check({tag, "_card_ready"}, 40'(bus.card_ready), 40'(m_state == 2));
    if (nbytes < 7) cs_pulse();
  endtask

  initial begin
    logic [47:0] f;
    logic        mi;
    int          nv0;
    int          sel;
    logic [5:0]  idx;

    bus.spi_clk = 1'b0;
    bus.spi_di  = 1'b1;
    bus.spi_cs  = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_spi_do", 40'(bus.spi_do), 40'd1);
    check("rst_cmd_valid", 40'(bus.cmd_valid), 40'd0);
    check("rst_cmd_index", 40'(bus.cmd_index), 40'd0);
    check("rst_card_ready", 40'(bus.card_ready), 40'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    bus.spi_cs = 1'b0;
    repeat (8) @(negedge clk);
    check("idle_spi_do", 40'(bus.spi_do), 40'd1);

    do_cmd(6'd8, 32'h0000_01AA, 1'b0, 7, "cmd8_uninit");
    do_cmd(6'd0, 32'h0, 1'b0, 7, "cmd0");
    do_cmd(6'd8, 32'h0000_01AA, 1'b0, 7, "cmd8");
    do_cmd(6'd58, 32'h0, 1'b0, 7, "cmd58_busy");
    do_cmd(6'd17, 32'h0000_0200, 1'b0, 7, "cmd17");
    do_cmd(6'd41, 32'h4000_0000, 1'b0, 7, "cmd41_noapp");
    for (int i = 0; i < 4; i++) begin
      do_cmd(6'd55, 32'h0, 1'b0, 7, $sformatf("cmd55_%0d", i));
      do_cmd(6'd41, 32'h4000_0000, 1'b0, 7, $sformatf("acmd41_%0d", i));
    end
    do_cmd(6'd58, 32'h0, 1'b0, 7, "cmd58_ready");

    // CS raised after 20 bits of CMD0: frame must vanish without a pulse
    f   = {2'b01, 6'd0, 32'h0, crc7(40'h40_0000_0000), 1'b1};
    nv0 = nvalid;
    for (int i = 47; i > 27; i--) xfer_bit(f[i], mi);
    cs_pulse();
    check("partial_frame_no_valid", 40'(nvalid), 40'(nv0));
    do_cmd(6'd0, 32'h0, 1'b0, 7, "cmd0_after_abort");

    do_cmd(6'd58, 32'h0, 1'b0, 2, "cmd58_cut");
    do_cmd(6'd8, 32'h0000_02A5, 1'b0, 7, "cmd8_after_cut");
    do_cmd(6'd0, 32'h0, 1'b1, 7, "cmd0_badcrc");

    for (int n = 0; n < 16; n++) begin
      sel = int'($urandom_range(0, 9));
      case (sel)
        0:       idx = 6'd55;
        1, 2:    idx = 6'd41;
        3:       idx = 6'd8;
        4:       idx = 6'd58;
        5:       idx = 6'd0;
        default: idx = 6'($urandom_range(1, 63));
      endcase
      do_cmd(idx, $urandom, 1'b0, 7, $sformatf("rand%0d_cmd%0d", n, idx));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
